vga_if_axi_intr_slave: RTL and testbench
========================================

# vga_if_axi_intr_slave

AXI4-Lite responder implementing the VGA interface's interrupt controller, i.e. the slave end of the S_AXI_INTR port that the bench masters drive. It latches rising edges on up to 32 interrupt sources into a sticky status register and masks them with global and per-source enables. It drives a registered, level-high `irq` line toward the processor. Software services an interrupt by reading the pending register and writing one-to-clear into the acknowledge register.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32, data bus width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 5, byte address width; decode uses bits [4:2].
- `C_NUM_OF_INTR`, 1, number of interrupt sources, 1..32.
- `s_axi_intr_aclk` in 1: the single clock.
- `s_axi_intr_aresetn` in 1: reset, asynchronous, active-low.
- `s_axi_intr_awaddr` in ADDR: write address.
- `s_axi_intr_awprot` in 3: ignored.
- `s_axi_intr_awvalid` / `s_axi_intr_awready`: in / out, 1 each.
- `s_axi_intr_wdata` in 32: write data.
- `s_axi_intr_wstrb` in 4: byte strobes.
- `s_axi_intr_wvalid` / `s_axi_intr_wready`: in / out, 1 each.
- `s_axi_intr_bresp` out 2: always 2'b00 (OKAY).
- `s_axi_intr_bvalid` / `s_axi_intr_bready`: out / in, 1 each.
- `s_axi_intr_araddr` in ADDR: read address.
- `s_axi_intr_arprot` in 3: ignored.
- `s_axi_intr_arvalid` / `s_axi_intr_arready`: in / out, 1 each.
- `s_axi_intr_rdata` out 32: read data.
- `s_axi_intr_rresp` out 2: always 2'b00 (OKAY).
- `s_axi_intr_rvalid` / `s_axi_intr_rready`: out / in, 1 each.
- `intr_in` in C_NUM_OF_INTR: interrupt sources, synchronous to the clock, rising-edge sensitive.
- `irq` out 1: interrupt request, active-high level.

## Operation
Register map, with bits above C_NUM_OF_INTR reading 0:
- 0x00 GIER, RW. Bit 0 is the global enable.
- 0x04 IER, RW. Per-source enable.
- 0x08 ISR, RO. Sticky raw status.
- 0x0C IAR, WO, reads 0. Write 1 clears the matching ISR bit.
- 0x10 IPR, RO. ISR & IER.
- 0x14 ISTR, optional; see Configuration.
- Any other offset: reads 0, writes ignored, response still OKAY.

Status and interrupt behaviour:
- `intr_in` is registered into `intr_d`. `edge = intr_in & ~intr_d`. A set edge bit sets the ISR bit at the next clock edge.
- `wstrb` applies to GIER and IER only. IAR (and ISTR, when present) act on the full word regardless of strobes.
- If an edge and an IAR clear hit the same bit in the same cycle, the set wins.
- `irq` is registered: `irq <= GIER[0] & |(ISR & IER)`, using current register values.
- Clearing IER or GIER does not clear ISR. Re-enabling with ISR still set re-asserts `irq`.

Write channel, states W_IDLE → W_RESP:
- In W_IDLE, when `awvalid & wvalid` are both high, assert `awready` and `wready` together for exactly one cycle and commit the write on that edge. Move to W_RESP with `bvalid=1`.
- In W_RESP, hold `bvalid` until `bready`, then return to W_IDLE.
- A lone `awvalid` or a lone `wvalid` waits; neither is accepted alone.

Read channel, states R_IDLE → R_DATA:
- In R_IDLE, when `arvalid` is high, pulse `arready` for one cycle. Capture `rdata` from register values at the handshake edge. Move to R_DATA with `rvalid=1`.
- In R_DATA, hold `rvalid` and `rdata` stable until `rready`, then return to R_IDLE.
- Read and write channels are independent. One outstanding transaction per channel.

## Timing
- Reset (async assert; deassert is sampled on a clock edge): all ready/valid outputs, `irq`, `rdata`, GIER, IER, ISR and `intr_d` are 0. Resp outputs are 00.
- Write: `awready`/`wready` high in cycle T. `bvalid` high from T+1. Next accept no earlier than the cycle after the `bvalid & bready` handshake.
- Read: `arready` in cycle T. `rvalid` from T+1. `rdata` reflects state at the T edge.
- Interrupt latency: `intr_in` rises and is sampled at edge E. ISR is set at E. `irq` rises at E+1.
- Acknowledge latency: IAR write handshake at edge E clears ISR at E. `irq` falls at E+1, unless another pending bit remains.
- An `intr_in` held high produces exactly one set. A new set requires the input to go low and then high again.
- Reset asserted mid-transaction aborts it. No response is issued after reset.

## Configuration
- `VGA_INTR_SW_TRIGGER_EN` defined: 0x14 ISTR is write-1-to-set into ISR and reads 0. It ORs with edges and, like edges, wins over IAR clears.
- Macro not defined: 0x14 is unmapped (reads 0, writes ignored, OKAY). No ISTR logic is present.

## Test plan
- Reset check: hold reset, then release. All outputs must be 0, and reads of 0x00–0x10 return 0x00000000.
- Register write/read: write GIER=0x00000001 and IER=0x00000001 (N=1), read both back, and confirm bresp=rresp=00. Write 0xFFFFFFFF to 0x18 and read it back as 0.
- Interrupt and clear: enable the interrupt, pulse `intr_in[0]`, and confirm `irq` rises 2 edges after the rise and IPR reads 0x00000001. Write IAR=0x00000001: `irq` falls 1 cycle after the handshake and IPR reads 0.
- Masking: with GIER=0, pulse the input. ISR reads 1 and `irq` stays 0. Write GIER=1 and `irq` asserts one cycle later.
- Collision and handshake: make the IAR write handshake coincide with a new rising edge, and ISR bit 0 must remain 1. Separately, delay `bready`/`rready` 5 cycles and confirm `bvalid`/`rvalid`/`rdata` are held stable and no second transaction is accepted.
- With `VGA_INTR_SW_TRIGGER_EN`: write 0x14=0x00000001 with the input idle, and `irq` must assert. Without the macro, the same write leaves ISR at 0.

Source files
------------

// File: rtl/vga_if_axi_intr_slave.sv
// vga_if_axi_intr_slave: AXI4-Lite slave for the VGA interrupt controller.
// Latches rising edges of intr_in into a sticky ISR, masks with IER/GIER and
// drives a registered level irq. Software acknowledges by writing 1s to IAR.
// Optional build macro: VGA_INTR_SW_TRIGGER_EN maps a write-1-to-set ISTR at 0x14.
module vga_if_axi_intr_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned C_NUM_OF_INTR      = 1
) (
    input  logic                            s_axi_intr_aclk,
    input  logic                            s_axi_intr_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_awaddr,
    input  logic [2:0]                      s_axi_intr_awprot,
    input  logic                            s_axi_intr_awvalid,
    output logic                            s_axi_intr_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_intr_wstrb,
    input  logic                            s_axi_intr_wvalid,
    output logic                            s_axi_intr_wready,
    output logic [1:0]                      s_axi_intr_bresp,
    output logic                            s_axi_intr_bvalid,
    input  logic                            s_axi_intr_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_araddr,
    input  logic [2:0]                      s_axi_intr_arprot,
    input  logic                            s_axi_intr_arvalid,
    output logic                            s_axi_intr_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_rdata,
    output logic [1:0]                      s_axi_intr_rresp,
    output logic                            s_axi_intr_rvalid,
    input  logic                            s_axi_intr_rready,
    input  logic [C_NUM_OF_INTR-1:0]        intr_in,
    output logic                            irq
);

    localparam int unsigned N = C_NUM_OF_INTR;

    typedef enum logic {StWIdle, StWResp} w_state_e;
    typedef enum logic {StRIdle, StRData} r_state_e;

    w_state_e     w_state_q, w_state_d;
    r_state_e     r_state_q, r_state_d;
    logic         wr_fire, rd_fire;
    logic [2:0]   wr_sel, rd_sel;
    logic         gier_q, gier_d;
    logic [N-1:0] ier_q, ier_d;
    logic [N-1:0] isr_q, isr_d;
    logic [N-1:0] intr_dly_q;
    logic [N-1:0] intr_edge;
    logic [N-1:0] iar_clr;
`ifdef VGA_INTR_SW_TRIGGER_EN
    logic [N-1:0] sw_set;
`endif
    logic [31:0]  ier_wr;
    logic [31:0]  rdata_q, rdata_d;
    logic         irq_q, irq_d;

    assign wr_sel    = s_axi_intr_awaddr[4:2];
    assign rd_sel    = s_axi_intr_araddr[4:2];
    assign intr_edge = intr_in & ~intr_dly_q;

    // Write channel FSM: address and data are only accepted together.
    always_comb begin
        w_state_d = w_state_q;
        wr_fire   = 1'b0;
        case (w_state_q)
            StWIdle: begin
                if (s_axi_intr_awvalid && s_axi_intr_wvalid) begin
                    wr_fire   = 1'b1;
                    w_state_d = StWResp;
                end
            end
            StWResp: begin
                if (s_axi_intr_bready) begin
                    w_state_d = StWIdle;
                end
            end
            default: w_state_d = StWIdle;
        endcase
        s_axi_intr_awready = wr_fire;
        s_axi_intr_wready  = wr_fire;
        s_axi_intr_bvalid  = (w_state_q == StWResp);
    end

    // Read channel FSM: rdata is captured at the address handshake.
    always_comb begin
        r_state_d = r_state_q;
        rd_fire   = 1'b0;
        case (r_state_q)
            StRIdle: begin
                if (s_axi_intr_arvalid) begin
                    rd_fire   = 1'b1;
                    r_state_d = StRData;
                end
            end
            StRData: begin
                if (s_axi_intr_rready) begin
                    r_state_d = StRIdle;
                end
            end
            default: r_state_d = StRIdle;
        endcase
        s_axi_intr_arready = rd_fire;
        s_axi_intr_rvalid  = (r_state_q == StRData);
    end

    // Register next-state: strobed GIER/IER, full-word IAR (and ISTR); sets beat clears.
    always_comb begin
        gier_d  = gier_q;
        ier_d   = ier_q;
        iar_clr = '0;
        ier_wr  = 32'(ier_q);
        for (int b = 0; b < 4; b++) begin
            if (s_axi_intr_wstrb[b]) begin
                ier_wr[8*b +: 8] = s_axi_intr_wdata[8*b +: 8];
            end
        end
        if (wr_fire && wr_sel == 3'd0 && s_axi_intr_wstrb[0]) begin
            gier_d = s_axi_intr_wdata[0];
        end
        if (wr_fire && wr_sel == 3'd1) begin
            ier_d = ier_wr[N-1:0];
        end
        if (wr_fire && wr_sel == 3'd3) begin
            iar_clr = s_axi_intr_wdata[N-1:0];
        end
`ifdef VGA_INTR_SW_TRIGGER_EN
        sw_set = '0;
        if (wr_fire && wr_sel == 3'd5) begin
            sw_set = s_axi_intr_wdata[N-1:0];
        end
        isr_d = (isr_q & ~iar_clr) | intr_edge | sw_set;
`else
        isr_d = (isr_q & ~iar_clr) | intr_edge;
`endif
        irq_d = gier_q & (|(isr_q & ier_q));
    end

    // Read data mux, sampled from current register values on the handshake.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_fire) begin
            case (rd_sel)
                3'd0:    rdata_d = {31'b0, gier_q};
                3'd1:    rdata_d = 32'(ier_q);
                3'd2:    rdata_d = 32'(isr_q);
                3'd4:    rdata_d = 32'(isr_q & ier_q);
                default: rdata_d = 32'b0;
            endcase
        end
    end

    // State and register update.
    always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            w_state_q  <= StWIdle;
            r_state_q  <= StRIdle;
            gier_q     <= 1'b0;
            ier_q      <= '0;
            isr_q      <= '0;
            intr_dly_q <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            gier_q     <= gier_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            intr_dly_q <= intr_in;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign s_axi_intr_rdata = rdata_q;
    assign s_axi_intr_bresp = 2'b00;
    assign s_axi_intr_rresp = 2'b00;
    assign irq              = irq_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot, s_axi_intr_awaddr,
                         s_axi_intr_araddr, s_axi_intr_wdata, ier_wr};

endmodule

// File: tb/tb_vga_if_axi_intr_slave.sv
// Self-checking bench for vga_if_axi_intr_slave (one interrupt source).
// Read results are checked against a queue of expected values pushed at issue.
module tb_vga_if_axi_intr_slave;

    logic        tb_ACLK = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [0:0]  intr_in;
    logic        irq;

    int          total = 0;
    int          bad = 0;
    logic        irq_after_commit;
    logic [31:0] exp_q[$];

    always #5 tb_ACLK = ~tb_ACLK;

    vga_if_axi_intr_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .C_NUM_OF_INTR(1)
    ) dut (
        .s_axi_intr_aclk(tb_ACLK),
        .s_axi_intr_aresetn(rst_n),
        .s_axi_intr_awaddr(awaddr),
        .s_axi_intr_awprot(awprot),
        .s_axi_intr_awvalid(awvalid),
        .s_axi_intr_awready(awready),
        .s_axi_intr_wdata(wdata),
        .s_axi_intr_wstrb(wstrb),
        .s_axi_intr_wvalid(wvalid),
        .s_axi_intr_wready(wready),
        .s_axi_intr_bresp(bresp),
        .s_axi_intr_bvalid(bvalid),
        .s_axi_intr_bready(bready),
        .s_axi_intr_araddr(araddr),
        .s_axi_intr_arprot(arprot),
        .s_axi_intr_arvalid(arvalid),
        .s_axi_intr_arready(arready),
        .s_axi_intr_rdata(rdata),
        .s_axi_intr_rresp(rresp),
        .s_axi_intr_rvalid(rvalid),
        .s_axi_intr_rready(rready),
        .intr_in(intr_in),
        .irq(irq)
    );

    // Full write; optionally raise intr_in[0] in the handshake cycle. Returns on a negedge.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic rise);
        int n;
        @(negedge tb_ACLK);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        if (rise) intr_in = 1'b1;
        #1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin
            @(negedge tb_ACLK); #1; n++;
        end
        total++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            bad++;
            $display("FAIL wr_accept addr=%h awready=%b wready=%b required 1/1", addr, awready,
                     wready);
        end
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        irq_after_commit = irq;
        total++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            bad++;
            $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b required 1/00", addr, bvalid, bresp);
        end
        bready = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        bready = 1'b0;
    endtask

    // Full read; expected value goes to the scoreboard and is popped when rvalid shows.
    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        int n;
        logic [31:0] want;
        exp_q.push_back(exp);
        @(negedge tb_ACLK);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin
            @(negedge tb_ACLK); #1; n++;
        end
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        arvalid = 1'b0;
        want = exp_q.pop_front();
        total++;
        if (rvalid !== 1'b1 || rdata !== want || rresp !== 2'b00) begin
            bad++;
            $display("FAIL %s rvalid=%b rdata=%h rresp=%b required 1/%h/00", name, rvalid, rdata,
                     rresp, want);
        end
        rready = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; intr_in = 0;
        repeat (3) @(negedge tb_ACLK);
        total++;
        if ({awready, wready, bvalid, arready, rvalid, irq} !== 6'b0 || rdata !== 32'h0 ||
            bresp !== 2'b00 || rresp !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs hs=%b irq=%b rdata=%h required all zero",
                     {awready, wready, bvalid, arready, rvalid}, irq, rdata);
        end
        rst_n = 1'b1;
        for (int a = 0; a < 5; a++) axi_read(5'(a * 4), 32'h0, "reset_read");
    endtask

    task automatic test_regs();
        axi_write(5'h00, 32'h1, 4'hF, 1'b0);
        axi_write(5'h04, 32'h1, 4'hF, 1'b0);
        axi_read(5'h00, 32'h1, "gier_rb");
        axi_read(5'h04, 32'h1, "ier_rb");
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_read(5'h18, 32'h0, "unmapped_rb");
        axi_read(5'h00, 32'h1, "gier_after_unmapped");
        axi_write(5'h04, 32'h0, 4'h0, 1'b0);
        axi_read(5'h04, 32'h1, "ier_strobe_off");
        axi_read(5'h0C, 32'h0, "iar_reads_zero");
    endtask

    task automatic test_intr();
        intr_in = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL irq_early got=%b required 0", irq);
        end
        @(negedge tb_ACLK);
        total++;
        if (irq !== 1'b1) begin
            bad++; $display("FAIL irq_rise got=%b required 1", irq);
        end
        intr_in = 1'b0;
        axi_read(5'h10, 32'h1, "ipr_pending");
        axi_write(5'h0C, 32'h1, 4'h0, 1'b0);
        total++;
        if (irq_after_commit !== 1'b1 || irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_ack at_commit=%b after=%b required 1/0", irq_after_commit, irq);
        end
        axi_read(5'h10, 32'h0, "ipr_cleared");
        // held-high input yields one set only
        intr_in = 1'b1;
        repeat (2) @(negedge tb_ACLK);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        repeat (2) @(negedge tb_ACLK);
        axi_read(5'h08, 32'h0, "isr_held_high");
        intr_in = 1'b0;
    endtask

    task automatic test_mask();
        axi_write(5'h00, 32'h0, 4'hF, 1'b0);
        intr_in = 1'b1;
        @(negedge tb_ACLK);
        intr_in = 1'b0;
        repeat (2) @(negedge tb_ACLK);
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL irq_masked got=%b required 0", irq);
        end
        axi_read(5'h08, 32'h1, "isr_masked");
        axi_write(5'h00, 32'h1, 4'hF, 1'b0);
        total++;
        if (irq_after_commit !== 1'b0 || irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_unmask at_commit=%b after=%b required 0/1", irq_after_commit, irq);
        end
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        repeat (2) @(negedge tb_ACLK);
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL irq_after_clear got=%b required 0", irq);
        end
    endtask

    task automatic test_collision();
        intr_in = 1'b1;
        @(negedge tb_ACLK);
        intr_in = 1'b0;
        @(negedge tb_ACLK);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b1);
        axi_read(5'h08, 32'h1, "isr_set_wins");
        intr_in = 1'b0;
        @(negedge tb_ACLK);
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
        axi_read(5'h08, 32'h0, "isr_cleared_after");
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        // write held in response phase while a second write is offered
        @(negedge tb_ACLK);
        awaddr = 5'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 0;
        #1;
        total++;
        if (awready !== 1'b1) begin
            bad++; $display("FAIL bp_wr_accept got=%b required 1", awready);
        end
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        awaddr = 5'h00; wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || bresp !== 2'b00) begin
                bad++;
                $display("FAIL bp_wr_hold cyc=%0d bvalid=%b awready=%b wready=%b required 1/0/0",
                         i, bvalid, awready, wready);
            end
            @(negedge tb_ACLK);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge tb_ACLK);
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0) begin
            bad++; $display("FAIL bp_wr_done bvalid=%b required 0", bvalid);
        end
        axi_read(5'h04, 32'h0, "bp_ier_written");
        axi_read(5'h00, 32'h1, "bp_gier_untouched");
        // read held while a second read is offered
        exp_q.push_back(32'h1);
        @(negedge tb_ACLK);
        araddr = 5'h00; arvalid = 1'b1;
        #1;
        total++;
        if (arready !== 1'b1) begin
            bad++; $display("FAIL bp_rd_accept got=%b required 1", arready);
        end
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        araddr = 5'h04;
        want = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== want) begin
                bad++;
                $display("FAIL bp_rd_hold cyc=%0d rvalid=%b arready=%b rdata=%h required 1/0/%h",
                         i, rvalid, arready, rdata, want);
            end
            @(negedge tb_ACLK);
        end
        arvalid = 1'b0; rready = 1'b1;
        want = exp_q.pop_front();
        @(negedge tb_ACLK);
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0) begin
            bad++; $display("FAIL bp_rd_done rvalid=%b required 0 (data %h)", rvalid, want);
        end
        axi_write(5'h04, 32'h1, 4'h1, 1'b0);
    endtask

    task automatic test_swtrig();
        axi_write(5'h14, 32'h1, 4'hF, 1'b0);
        repeat (2) @(negedge tb_ACLK);
`ifdef VGA_INTR_SW_TRIGGER_EN
        total++;
        if (irq !== 1'b1) begin
            bad++; $display("FAIL swtrig_irq got=%b required 1", irq);
        end
        axi_read(5'h08, 32'h1, "swtrig_isr");
        axi_read(5'h14, 32'h0, "istr_reads_zero");
        axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
`else
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL swtrig_off_irq got=%b required 0", irq);
        end
        axi_read(5'h08, 32'h0, "swtrig_off_isr");
`endif
    endtask

    task automatic test_reset_abort();
        @(negedge tb_ACLK);
        awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 0;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (bvalid !== 1'b0 || irq !== 1'b0) begin
            bad++; $display("FAIL abort_async bvalid=%b irq=%b required 0/0", bvalid, irq);
        end
        @(negedge tb_ACLK);
        rst_n = 1'b1; bready = 1'b1;
        repeat (3) @(negedge tb_ACLK);
        total++;
        if (bvalid !== 1'b0) begin
            bad++; $display("FAIL abort_no_resp bvalid=%b required 0", bvalid);
        end
        bready = 1'b0;
        axi_read(5'h00, 32'h0, "abort_gier_reset");
    endtask

    initial begin
        test_reset();
        test_regs();
        test_intr();
        test_mask();
        test_collision();
        test_back_to_back();
        test_swtrig();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
